// File: rtl/i2c_config_sequencer.sv
// Walks a 24-bit config table into an I2C byte-write controller after a power-up delay, retrying failed words.
// Latency: 2 fetch + 2 go-low + controller time + 1 check cycles per attempt; DONE/ERR one cycle after the final check.
// Backpressure: GO/END handshake per word, next word only after END or timeout; optional retry via I2C_CFG_RETRY_EN.
module i2c_config_sequencer #(
  parameter int NUM_WORDS    = 16,
  parameter int ADDR_W       = 4,
  parameter int PWR_DELAY    = 50000,
  parameter int MAX_RETRY    = 3,
  parameter int XFER_TIMEOUT = 48
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              START,
  output logic [ADDR_W-1:0] TBL_ADDR,
  input  logic [23:0]       TBL_DATA,
  output logic [23:0]       I2C_DATA,
  output logic              GO,
  input  logic              END,
  input  logic              ACK,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [ADDR_W-1:0] ERR_INDEX
);

  typedef enum logic [2:0] {
    S_DELAY,
    S_FETCH,
    S_GOLOW,
    S_WAIT,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  localparam int TMO_W = 16;
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_WORDS - 1);
  localparam logic [TMO_W-1:0]  END_IGNORE = TMO_W'(2);
  localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(XFER_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [31:0]       delay_cnt_q, delay_cnt_d;
  logic              phase_q, phase_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] tbl_addr_q, tbl_addr_d;
  logic [23:0]       i2c_data_q, i2c_data_d;
  logic              go_q, go_d;
  logic              fail_q, fail_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_index_q, err_index_d;
  logic              retry_ok;

`ifdef I2C_CFG_RETRY_EN
  logic [3:0] retry_cnt_q, retry_cnt_d;
  assign retry_ok = (retry_cnt_q < 4'(MAX_RETRY));
`else
  logic [31:0] unused_max_retry;
  assign unused_max_retry = 32'(MAX_RETRY);
  assign retry_ok = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    delay_cnt_d = delay_cnt_q;
    phase_d     = phase_q;
    tmo_cnt_d   = tmo_cnt_q;
    idx_d       = idx_q;
    tbl_addr_d  = tbl_addr_q;
    i2c_data_d  = i2c_data_q;
    go_d        = go_q;
    fail_d      = fail_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    err_index_d = err_index_q;
`ifdef I2C_CFG_RETRY_EN
    retry_cnt_d = retry_cnt_q;
`endif

    case (state_q)
      S_DELAY: begin
        if (delay_cnt_q == 32'(PWR_DELAY)) begin
          state_d    = S_FETCH;
          idx_d      = '0;
          tbl_addr_d = '0;
          phase_d    = 1'b0;
        end else begin
          delay_cnt_d = delay_cnt_q + 32'd1;
        end
      end

      // Table read is registered: data for TBL_ADDR arrives on the second cycle.
      S_FETCH: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d    = 1'b0;
          i2c_data_d = TBL_DATA;
          state_d    = S_GOLOW;
        end
      end

      S_GOLOW: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d   = 1'b0;
          tmo_cnt_d = '0;
          go_d      = 1'b1;
          state_d   = S_WAIT;
        end
      end

      // END may still be stale from the previous transfer for the first two cycles.
      S_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if ((tmo_cnt_q >= END_IGNORE) && END) begin
          fail_d  = ACK;
          go_d    = 1'b0;
          state_d = S_CHECK;
        end else if (tmo_cnt_q >= TMO_LAST) begin
          fail_d  = 1'b1;
          go_d    = 1'b0;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        phase_d = 1'b0;
        if (!fail_q) begin
`ifdef I2C_CFG_RETRY_EN
          retry_cnt_d = '0;
`endif
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d      = idx_q + 1'b1;
            tbl_addr_d = idx_q + 1'b1;
            state_d    = S_FETCH;
          end
        end else if (retry_ok) begin
`ifdef I2C_CFG_RETRY_EN
          retry_cnt_d = retry_cnt_q + 1'b1;
`endif
          state_d = S_GOLOW;
        end else begin
          state_d     = S_ERR;
          busy_d      = 1'b0;
          err_d       = 1'b1;
          err_index_d = idx_q;
        end
      end

      S_DONE, S_ERR: begin
        if (START) begin
          state_d     = S_DELAY;
          delay_cnt_d = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          err_d       = 1'b0;
          err_index_d = '0;
`ifdef I2C_CFG_RETRY_EN
          retry_cnt_d = '0;
`endif
        end
      end

      default: state_d = S_DELAY;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q     <= S_DELAY;
      delay_cnt_q <= '0;
      phase_q     <= 1'b0;
      tmo_cnt_q   <= '0;
      idx_q       <= '0;
      tbl_addr_q  <= '0;
      i2c_data_q  <= '0;
      go_q        <= 1'b0;
      fail_q      <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_index_q <= '0;
`ifdef I2C_CFG_RETRY_EN
      retry_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      delay_cnt_q <= delay_cnt_d;
      phase_q     <= phase_d;
      tmo_cnt_q   <= tmo_cnt_d;
      idx_q       <= idx_d;
      tbl_addr_q  <= tbl_addr_d;
      i2c_data_q  <= i2c_data_d;
      go_q        <= go_d;
      fail_q      <= fail_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_index_q <= err_index_d;
`ifdef I2C_CFG_RETRY_EN
      retry_cnt_q <= retry_cnt_d;
`endif
    end
  end

  assign TBL_ADDR  = tbl_addr_q;
  assign I2C_DATA  = i2c_data_q;
  assign GO        = go_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign ERR_INDEX = err_index_q;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Scoreboard bench for i2c_config_sequencer: a word-level reference model predicts every GO attempt and the final outcome.
module tb_i2c_config_sequencer;

  localparam int NW  = 3;
  localparam int AW  = 4;
  localparam int PD  = 4;
  localparam int MR  = 3;
  localparam int TMO = 48;
`ifdef I2C_CFG_RETRY_EN
  localparam int LIM = MR;
`else
  localparam int LIM = 0;
`endif
  localparam logic [1:0] K_ACK = 2'd0, K_NACK = 2'd1, K_TMO = 2'd2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] tbl_addr;
  logic [23:0]   tbl_data = '0;
  logic [23:0]   i2c_data;
  logic          go;
  logic          end_f = 1'b0;
  logic          ack = 1'b0;
  logic          busy, done, err;
  logic [AW-1:0] err_index;

  always #5 clk = ~clk;

  i2c_config_sequencer #(
    .NUM_WORDS(NW), .ADDR_W(AW), .PWR_DELAY(PD), .MAX_RETRY(MR), .XFER_TIMEOUT(TMO)
  ) dut (
    .CLOCK(clk), .RESET(rst_n), .START(start), .TBL_ADDR(tbl_addr), .TBL_DATA(tbl_data),
    .I2C_DATA(i2c_data), .GO(go), .END(end_f), .ACK(ack), .BUSY(busy), .DONE(done),
    .ERR(err), .ERR_INDEX(err_index)
  );

  typedef struct packed { logic [23:0] data; logic [1:0] kind; } att_t;
  typedef struct packed { logic done; logic err; logic [3:0] idx; } out_t;

  att_t        wq[$];
  logic [1:0]  rq[$];
  out_t        oq[$];
  logic [23:0] mem [16];
  int          fails [NW];
  logic [1:0]  fail_mode;
  int          n_pass = 0;
  int          n_total = 0;
  int          n_cmpl = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Word-level model: each word fails fails[w] times before acking; at most LIM retries.
  task automatic plan();
    att_t a;
    out_t o;
    bit   ok;
    for (int w = 0; w < NW; w++) begin
      ok = 1'b0;
      for (int t = 0; t <= LIM; t++) begin
        a.data = mem[w];
        if (t < fails[w]) a.kind = (fail_mode == 2'd3) ? 2'($urandom_range(1, 2)) : fail_mode;
        else a.kind = K_ACK;
        wq.push_back(a);
        rq.push_back(a.kind);
        if (a.kind == K_ACK) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        o.done = 1'b0; o.err = 1'b1; o.idx = 4'(w);
        oq.push_back(o);
        return;
      end
    end
    o.done = 1'b1; o.err = 1'b0; o.idx = 4'd0;
    oq.push_back(o);
  endtask

  // Registered table memory.
  logic [AW-1:0] rd_addr;
  initial forever begin
    @(negedge clk);
    rd_addr = tbl_addr;
    @(posedge clk);
    #1 tbl_data = mem[rd_addr];
  end

  // Controller model: END after a random latency unless this attempt is a timeout.
  int         c_cnt, c_lat;
  logic [1:0] c_kind;
  bit         c_act = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    if (go !== 1'b1) begin
      c_act = 1'b0; end_f = 1'b0; ack = 1'b0;
    end else begin
      if (!c_act) begin
        c_act  = 1'b1;
        c_cnt  = 0;
        c_kind = (rq.size() != 0) ? rq.pop_front() : K_ACK;
        c_lat  = int'($urandom_range(3, 33));
      end
      c_cnt++;
      if (c_kind != K_TMO && c_cnt >= c_lat) begin
        end_f = 1'b1;
        ack   = (c_kind == K_NACK);
      end
    end
  end

  // Monitor: pops expected attempts on GO rise and expected outcome on BUSY fall.
  bit   prev_go = 1'b0, prev_busy = 1'b1;
  att_t cur;
  out_t o_exp;
  int   go_len, unstable;
  initial forever begin
    @(negedge clk);
    if (go === 1'b1 && !prev_go) begin
      chk("attempt_expected", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        cur = wq.pop_front();
        chk("i2c_data", 32'(i2c_data), 32'(cur.data));
      end else begin
        cur.data = i2c_data; cur.kind = K_ACK;
      end
      go_len = 0; unstable = 0;
    end
    if (go === 1'b1) begin
      go_len++;
      if (i2c_data !== cur.data) unstable++;
    end
    if (go === 1'b0 && prev_go) begin
      chk("data_stable_while_go", 32'(unstable), 32'd0);
      if (cur.kind == K_TMO) chk("timeout_go_cycles", 32'(go_len), 32'(TMO));
    end
    if (busy === 1'b0 && prev_busy) begin
      chk("outcome_expected", 32'(oq.size() != 0), 32'd1);
      if (oq.size() != 0) begin
        o_exp = oq.pop_front();
        chk("done", 32'(done), 32'(o_exp.done));
        chk("err", 32'(err), 32'(o_exp.err));
        chk("err_index", 32'(err_index), 32'(o_exp.idx));
        chk("go_idle", 32'(go), 32'd0);
        chk("attempts_left", 32'(wq.size()), 32'd0);
      end
      n_cmpl++;
    end
    prev_go   = (go === 1'b1);
    prev_busy = (busy !== 1'b0);
  end

  task automatic chk_reset_vals();
    chk("rst_tbl_addr", 32'(tbl_addr), 32'd0);
    chk("rst_i2c_data", 32'(i2c_data), 32'd0);
    chk("rst_go", 32'(go), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_index", 32'(err_index), 32'd0);
  endtask

  task automatic go_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("start_clears_done", 32'(done), 32'd0);
    chk("start_clears_err", 32'(err), 32'd0);
    chk("start_sets_busy", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int budget, input bit poke);
    int s;
    s = n_cmpl;
    for (int i = 0; i < budget && n_cmpl == s; i++) begin
      @(posedge clk); #1;
      if (poke && i == 20) begin
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    end
    chk("sequence_completes", 32'(n_cmpl - s), 32'd1);
  endtask

  bit found;
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 24'($urandom);
    fail_mode = K_NACK;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();

    // Basic codec table, all words acked.
    mem[0] = 24'h341E00; mem[1] = 24'h341201; mem[2] = 24'h340C00;
    fails = '{0, 0, 0};
    plan();
    @(posedge clk); #1 rst_n = 1'b1;
    wait_done(2000, 1'b0);
    repeat (5) @(negedge clk);
    chk("done_sticky", 32'(done), 32'd1);
    chk("busy_idle", 32'(busy), 32'd0);

    // Word 1 NACKs twice.
    fails = '{0, 2, 0}; fail_mode = K_NACK;
    plan(); go_start(); wait_done(3000, 1'b0);

    // Word 2 always NACKs.
    fails = '{0, 0, 99}; fail_mode = K_NACK;
    plan(); go_start(); wait_done(3000, 1'b0);

    // Word 1 never completes: every attempt times out.
    fails = '{0, 99, 0}; fail_mode = K_TMO;
    plan(); go_start(); wait_done(3000, 1'b0);

    // One-cycle reset during word 1's wait, then full restart.
    fails = '{0, 0, 0}; fail_mode = K_NACK;
    plan(); go_start();
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (go === 1'b1 && tbl_addr == 4'd1) found = 1'b1;
    end
    chk("reached_word1_wait", 32'(found), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    wq.delete(); rq.delete(); oq.delete();
    plan();
    @(negedge clk);
    chk_reset_vals();
    wait_done(3000, 1'b0);

    // START while busy must be ignored.
    for (int w = 0; w < NW; w++) mem[w] = 24'($urandom);
    fails = '{0, 0, 0};
    plan(); go_start(); wait_done(3000, 1'b1);

    // Randomized tables and failure patterns.
    repeat (8) begin
      for (int w = 0; w < NW; w++) begin
        int r;
        mem[w]   = 24'($urandom);
        r        = int'($urandom_range(0, 4));
        fails[w] = (r == 4) ? 99 : r;
      end
      fail_mode = 2'd3;
      plan(); go_start(); wait_done(4000, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
